// File: rtl/fpf_decoder_12.sv
// fpf_decoder_12: two-stage FPF Fibonacci decoder for 12-wire CAC codewords, with error flag and saturating error counter
module fpf_decoder_12 #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          code_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8:0]           data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_error,
  input  logic                 err_clear,
  output logic [CNT_WIDTH-1:0] err_count
);
  localparam logic [8:0] FNS [12] = '{9'd1, 9'd1, 9'd2, 9'd3, 9'd5, 9'd8, 9'd13, 9'd21, 9'd34, 9'd55, 9'd89, 9'd144};
  logic [8:0] p [3];
  logic [8:0] s1_p [3];
  logic       fpe, s1_err, s1_valid, s2_free;
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  always_comb begin
    p   = '{default: '0};
    fpe = 1'b0;
    for (int g = 0; g < 3; g++)
      for (int b = 0; b < 4; b++)
        p[g] = p[g] + (code_in[4*g+b] ? FNS[4*g+b] : 9'd0);
    for (int i = 0; i < 10; i++)
      fpe = fpe | (code_in[i+:3] == 3'b010) | (code_in[i+:3] == 3'b101);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_p      <= '{default: '0};
      s1_err    <= 1'b0;
      s1_valid  <= 1'b0;
      data_out  <= '0;
      out_error <= 1'b0;
      out_valid <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_p   <= p;
          s1_err <= fpe;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          data_out  <= s1_p[0] + s1_p[1] + s1_p[2];
          out_error <= s1_err;
        end
      end
      if (err_clear) err_count <= '0;
      else if (out_valid && out_ready && out_error && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
endmodule
